semaforo_cruzamento: RTL and testbench

- Parametrised two-road intersection traffic-light controller.
- Drives road A and road B lamps from one state machine with per-phase durations set by parameters.
- Inserts an all-red clearance between directions.
- Optionally serves a pedestrian push-button by shortening the active green and holding a pedestrian walk phase.

---
 rtl/semaforo_cruzamento.sv | 139 +++++++++++++
 tb/tb_semaforo_cruzamento.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/semaforo_cruzamento.sv
// semaforo_cruzamento: two-road intersection traffic-light controller.
// Cycle VA -> AA -> RA -> VB -> AB -> RB -> VA. There is an all-red clearance between
// the two directions, and each phase duration is set by a parameter.
// Optional macro SEMAFORO_PEDESTRE_EN adds the pedestrian button. A press cuts the active
// green once it reaches its minimum length, and the next all-red becomes a walk phase.
module semaforo_cruzamento #(
    parameter int unsigned T_VERDE_A   = 8,
    parameter int unsigned T_VERDE_B   = 6,
    parameter int unsigned T_AMARELO   = 3,
    parameter int unsigned T_VERMELHO  = 2,
    parameter int unsigned T_VERDE_MIN = 3,
    parameter int unsigned T_PEDESTRE  = 5,
    parameter int unsigned CW          = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic       W
);

    typedef enum logic [2:0] {VA, AA, RA, VB, AB, RB} estado_t;

    localparam logic [2:0] VERDE    = 3'b100;
    localparam logic [2:0] AMARELO  = 3'b010;
    localparam logic [2:0] VERMELHO = 3'b001;

    // Terminal counts: a phase of T cycles is left when cnt reaches T-1
    localparam logic [CW-1:0] FIM_VA = CW'(T_VERDE_A - 1);
    localparam logic [CW-1:0] FIM_VB = CW'(T_VERDE_B - 1);
    localparam logic [CW-1:0] FIM_AM = CW'(T_AMARELO - 1);
    localparam logic [CW-1:0] FIM_VM = CW'(T_VERMELHO - 1);

    estado_t       estado, prox;
    logic [CW-1:0] cnt;
    logic          fim;       // leave the current state at this edge
    logic          entra_vm;  // yellow -> all-red edge
    logic          corte;     // pedestrian request cuts the active green
    logic [CW-1:0] fim_vm;    // terminal count of the all-red state (walk or clearance)
    logic          req;
    logic          ped;

`ifdef SEMAFORO_PEDESTRE_EN
    localparam logic [CW-1:0] FIM_MIN = CW'(T_VERDE_MIN - 1);
    localparam logic [CW-1:0] FIM_PED = CW'(T_PEDESTRE - 1);

    assign corte  = req && (estado == VA || estado == VB) && (cnt >= FIM_MIN);
    assign fim_vm = ped ? FIM_PED : FIM_VM;

    // Request latch and walk flag; presses on all-red entry or during the walk are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req <= 1'b0;
            ped <= 1'b0;
        end else if (entra_vm) begin
            ped <= req;
            req <= 1'b0;
        end else begin
            if (bt && !ped) req <= 1'b1;
            if (fim && ped) ped <= 1'b0;
        end
    end
`else
    logic unused_ok;

    assign corte     = 1'b0;
    assign fim_vm    = FIM_VM;
    assign req       = 1'b0;
    assign ped       = 1'b0;
    assign unused_ok = bt ^ (T_VERDE_MIN == T_PEDESTRE);
`endif

    // State register and phase counter; the counter restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= VA;
            cnt    <= '0;
        end else begin
            estado <= prox;
            cnt    <= fim ? '0 : cnt + 1'b1;
        end
    end

    // Next state: advance on phase expiry or on an early green cut
    always_comb begin
        prox     = estado;
        fim      = 1'b0;
        entra_vm = 1'b0;
        unique case (estado)
            VA: begin
                fim = (cnt == FIM_VA) || corte;
                if (fim) prox = AA;
            end
            AA: begin
                fim = (cnt == FIM_AM);
                if (fim) prox = RA;
                entra_vm = fim;
            end
            RA: begin
                fim = (cnt == fim_vm);
                if (fim) prox = VB;
            end
            VB: begin
                fim = (cnt == FIM_VB) || corte;
                if (fim) prox = AB;
            end
            AB: begin
                fim = (cnt == FIM_AM);
                if (fim) prox = RB;
                entra_vm = fim;
            end
            RB: begin
                fim = (cnt == fim_vm);
                if (fim) prox = VA;
            end
            default: begin
                fim  = 1'b1;
                prox = VA;
            end
        endcase
    end

    // Lamp decode from the state register only (Moore)
    always_comb begin
        A = VERMELHO;
        B = VERMELHO;
        unique case (estado)
            VA:      A = VERDE;
            AA:      A = AMARELO;
            VB:      B = VERDE;
            AB:      B = AMARELO;
            default: ;
        endcase
    end

    assign W = ped;

endmodule

// File: tb/tb_semaforo_cruzamento.sv
// Bench for semaforo_cruzamento. A phase-table model predicts the lamps on every cycle.
// Literal checkpoints pin the expected timeline at chosen cycles.
module tb_semaforo_cruzamento;

    localparam int TVA = 8, TVB = 6, TAM = 3, TVM = 2, TMIN = 3, TPED = 5;
`ifdef SEMAFORO_PEDESTRE_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    // Phase table in cyclic order: VA AA RA VB AB RB
    localparam int         DUR   [6] = '{TVA, TAM, TVM, TVB, TAM, TVM};
    localparam logic [2:0] LAMPA [6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
    localparam logic [2:0] LAMPB [6] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bt  = 1'b0;
    logic [2:0] A, B;
    logic       W;

    int n_cmp = 0;
    int n_err = 0;

    semaforo_cruzamento #(
        .T_VERDE_A(TVA), .T_VERDE_B(TVB), .T_AMARELO(TAM), .T_VERMELHO(TVM),
        .T_VERDE_MIN(TMIN), .T_PEDESTRE(TPED), .CW(9)
    ) dut (
        .clk(clk), .rst(rst), .bt(bt), .A(A), .B(B), .W(W)
    );

    always #5 clk = ~clk;

    // Model: phase index, cycles already spent in it, pending request, walk active
    int  mp = 0, mt = 0;
    bit  mreq = 0, mped = 0;
    int  m_dur;
    bit  m_go, m_into_red;

    always_comb begin
        m_dur = DUR[mp];
        if ((mp == 2 || mp == 5) && mped) m_dur = TPED;
        m_go = (mt + 1 >= m_dur) ||
               (PED && (mp == 0 || mp == 3) && mreq && (mt + 1 >= TMIN));
        m_into_red = m_go && (mp == 1 || mp == 4);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mp <= 0; mt <= 0; mreq <= 0; mped <= 0;
        end else begin
            mp <= m_go ? (mp + 1) % 6 : mp;
            mt <= m_go ? 0 : mt + 1;
            if (PED) begin
                if (m_into_red) begin
                    mped <= mreq;
                    mreq <= 1'b0;
                end else begin
                    if (bt && !mped) mreq <= 1'b1;
                    if (m_go && mped) mped <= 1'b0;
                end
            end
        end
    end

    task automatic check_model();
        logic [6:0] exp_v, got_v;
        exp_v = {LAMPA[mp], LAMPB[mp], mped && (mp == 2 || mp == 5)};
        got_v = {A, B, W};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL model t=%0t A/B/W got %b/%b/%b want %b/%b/%b", $time,
                     A, B, W, exp_v[6:4], exp_v[3:1], exp_v[0]);
        end
    endtask

    task automatic pin(input string nm, input logic [2:0] ea, input logic [2:0] eb, input logic ew);
        n_cmp++;
        if ({A, B, W} !== {ea, eb, ew}) begin
            n_err++;
            $display("FAIL %s t=%0t A/B/W got %b/%b/%b want %b/%b/%b", nm, $time, A, B, W, ea, eb, ew);
        end
    endtask

    // Advance n clock edges, checking the model at each following falling edge
    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_model();
        end
    endtask

    // Reset for two cycles; returns at cycle 0 of VA (before its first edge)
    task automatic do_reset();
        rst = 1'b1;
        bt  = 1'b0;
        adv(2);
        pin("rst_hold", 3'b100, 3'b001, 1'b0);
        rst = 1'b0;
        check_model();
    endtask

    initial begin
        @(negedge clk);

        // Nominal cycle, no button
        do_reset();
        pin("nom_va0", 3'b100, 3'b001, 1'b0);
        adv(7);  pin("nom_va7", 3'b100, 3'b001, 1'b0);
        adv(1);  pin("nom_aa", 3'b010, 3'b001, 1'b0);
        adv(3);  pin("nom_ra", 3'b001, 3'b001, 1'b0);
        adv(2);  pin("nom_vb", 3'b001, 3'b100, 1'b0);
        adv(6);  pin("nom_ab", 3'b001, 3'b010, 1'b0);
        adv(3);  pin("nom_rb", 3'b001, 3'b001, 1'b0);
        adv(2);  pin("nom_va24", 3'b100, 3'b001, 1'b0);
        adv(24); pin("nom_va48", 3'b100, 3'b001, 1'b0);

`ifdef SEMAFORO_PEDESTRE_EN
        // Press at VA cnt=5: VA lasts 7, walk all-red lasts 5
        do_reset();
        adv(5);  bt = 1'b1;
        adv(1);  bt = 1'b0;
        pin("p5_va6", 3'b100, 3'b001, 1'b0);
        adv(1);  pin("p5_aa", 3'b010, 3'b001, 1'b0);
        adv(3);  pin("p5_walk0", 3'b001, 3'b001, 1'b1);
        adv(4);  pin("p5_walk4", 3'b001, 3'b001, 1'b1);
        adv(1);  pin("p5_vb", 3'b001, 3'b100, 1'b0);
        adv(10);

        // Press at VA cnt=0: green cut at its minimum
        do_reset();
        bt = 1'b1;
        adv(1);  bt = 1'b0;
        adv(1);  pin("p0_va2", 3'b100, 3'b001, 1'b0);
        adv(1);  pin("p0_aa", 3'b010, 3'b001, 1'b0);
        adv(3);  pin("p0_walk", 3'b001, 3'b001, 1'b1);
        adv(4);  pin("p0_walk4", 3'b001, 3'b001, 1'b1);
        adv(1);  pin("p0_vb", 3'b001, 3'b100, 1'b0);

        // Button held 40 cycles: every green cut to 3, one walk per all-red
        do_reset();
        bt = 1'b1;
        adv(13); pin("hold_vb2", 3'b001, 3'b100, 1'b0);
        adv(1);  pin("hold_ab", 3'b001, 3'b010, 1'b0);
        adv(3);  pin("hold_rbw", 3'b001, 3'b001, 1'b1);
        adv(4);  pin("hold_rbw4", 3'b001, 3'b001, 1'b1);
        adv(1);  pin("hold_va", 3'b100, 3'b001, 1'b0);
        adv(2);  pin("hold_va2", 3'b100, 3'b001, 1'b0);
        adv(1);  pin("hold_aa", 3'b010, 3'b001, 1'b0);
        adv(14);
        bt = 1'b0;
        adv(30);
`endif

        // Reset mid-AB with a press just before it: async restart, no request kept
        do_reset();
        adv(19); pin("mid_ab", 3'b001, 3'b010, 1'b0);
        bt = 1'b1;
        adv(1);  bt = 1'b0;
        rst = 1'b1;
        #1;
        pin("async_rst", 3'b100, 3'b001, 1'b0);
        check_model();
        @(negedge clk);
        rst = 1'b0;
        check_model();
        adv(7);  pin("rst_va7", 3'b100, 3'b001, 1'b0);
        adv(1);  pin("rst_aa", 3'b010, 3'b001, 1'b0);

        // Random button activity
        do_reset();
        for (int i = 0; i < 80; i++) begin
            bt = 1'($urandom_range(0, 1));
            adv(1);
        end
        bt = 1'b0;
`ifndef SEMAFORO_PEDESTRE_EN
        // Without the pedestrian feature the random presses change nothing
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bt = 1'($urandom_range(0, 1));
            adv(1);
        end
        pin("nob_va7", 3'b100, 3'b001, 1'b0);
        adv(1);  pin("nob_aa", 3'b010, 3'b001, 1'b0);
        bt = 1'b0;
`endif
        adv(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
